bbpd_loop_ctrl: RTL and testbench

BBPD_LOOP_CTRL -- requirements
Module: bbpd_loop_ctrl

---
 rtl/bbpd_loop_ctrl_pkg.sv | 16 +
 rtl/bbpd_loop_ctrl_if.sv | 25 ++
 rtl/bbpd_vote_acc.sv | 64 ++++++
 rtl/bbpd_loop_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bbpd_loop_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bbpd_loop_ctrl_pkg.sv
// Shared types for the bang-bang phase-detector loop controller.
// Provides the default-width PI code type and the loop FSM state enum.
// No ports; imported by the interface, sub-module and top.
package bbpd_loop_ctrl_pkg;

  localparam int PI_BITS_DEF = 8;

  typedef logic [PI_BITS_DEF-1:0] pi_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } loop_state_t;

endpackage

// File: rtl/bbpd_loop_ctrl_if.sv
// Bus between the phase detector side and the loop controller.
// Signals: en/up/dn (votes in), pi_code/code_valid/locked (loop out).
// master drives the votes, slave (the controller) drives the code.
interface bbpd_loop_ctrl_if #(
  parameter int PI_BITS = 8
) ();

  logic               en;
  logic               up;
  logic               dn;
  logic [PI_BITS-1:0] pi_code;
  logic               code_valid;
  logic               locked;

  modport master (
    output en, up, dn,
    input  pi_code, code_valid, locked
  );

  modport slave (
    input  en, up, dn,
    output pi_code, code_valid, locked
  );

endinterface

// File: rtl/bbpd_vote_acc.sv
// Decodes up/dn into +1/-1/0 votes and sums them over WIN_LEN enabled samples.
// Ports: clk, rst, en_i/up_i/dn_i in; sum_o (signed window sum), win_done_o (1-cycle pulse).
// sum_o/win_done_o update on the edge sampling the last vote; en_i low discards a partial window.
module bbpd_vote_acc #(
  parameter int WIN_LEN = 16,
  parameter int SW      = $clog2(WIN_LEN) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 up_i,
  input  logic                 dn_i,
  output logic signed [SW-1:0] sum_o,
  output logic                 win_done_o
);

  localparam int CW = $clog2(WIN_LEN);

  logic [CW-1:0]        cnt_q;
  logic signed [SW-1:0] acc_q;
  logic signed [SW-1:0] sum_q;
  logic                 done_q;
  logic signed [SW-1:0] vote;
  logic                 last;

  always_comb begin
    vote = '0;
    if (up_i && !dn_i) begin
      vote = {{(SW-1){1'b0}}, 1'b1};
    end else if (dn_i && !up_i) begin
      vote = '1;
    end
  end

  assign last = (cnt_q == CW'(WIN_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!en_i) begin
        // Dropping enable throws the partial window away.
        cnt_q <= '0;
        acc_q <= '0;
      end else if (last) begin
        cnt_q  <= '0;
        acc_q  <= '0;
        sum_q  <= acc_q + vote;
        done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_q + vote;
      end
    end
  end

  assign sum_o      = sum_q;
  assign win_done_o = done_q;

endmodule

// File: rtl/bbpd_loop_ctrl.sv
// CDR loop filter: windowed bbpd votes -> proportional (+ optional integral) PI code update and lock FSM.
// Ports: clk, rst, bus (slave: en/up/dn in, pi_code/code_valid/locked out).
// pi_code/code_valid land two edges after the closing vote; BBPD_CTRL_INTEGRAL_EN enables the integral path.
module bbpd_loop_ctrl
  import bbpd_loop_ctrl_pkg::*;
#(
  parameter int WIN_LEN  = 16,
  parameter int PI_BITS  = 8,
  parameter int INT_BITS = 12,
  parameter int KP       = 2,
  parameter int KI_SHIFT = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic            clk,
  input  logic            rst,
  bbpd_loop_ctrl_if.slave bus
);

  localparam int SW = $clog2(WIN_LEN) + 2;
  localparam int QW = $clog2(LOCK_CNT + 1);

  logic signed [SW-1:0] win_sum;
  logic                 win_done;
  logic signed [SW-1:0] abs_sum;
  logic                 win_quiet;
  logic                 win_loud;

  // Stage 2: window result captured one edge after the window closes.
  logic s2_vld_q, s2_pos_q, s2_neg_q, s2_quiet_q, s2_loud_q;

  logic [PI_BITS-1:0] pi_code_q, pi_code_d;
  logic [PI_BITS-1:0] kp_term, integ_term;
  logic               code_valid_q;

  loop_state_t   state_q;
  logic [QW-1:0] quiet_cnt_q;
  logic          locked_q;

  bbpd_vote_acc #(
    .WIN_LEN (WIN_LEN),
    .SW      (SW)
  ) u_vote_acc (
    .clk        (clk),
    .rst        (rst),
    .en_i       (bus.en),
    .up_i       (bus.up),
    .dn_i       (bus.dn),
    .sum_o      (win_sum),
    .win_done_o (win_done)
  );

  assign abs_sum   = win_sum[SW-1] ? -win_sum : win_sum;
  assign win_quiet = (abs_sum <= $signed(SW'(1)));
  assign win_loud  = (abs_sum > $signed(SW'(WIN_LEN / 2)));

`ifdef BBPD_CTRL_INTEGRAL_EN
  logic signed [INT_BITS-1:0] integral_q, integral_d;
  logic signed [INT_BITS:0]   int_sum;

  always_comb begin
    int_sum    = $signed({integral_q[INT_BITS-1], integral_q})
               + $signed((INT_BITS+1)'(win_sum));
    integral_d = int_sum[INT_BITS-1:0];
    // Top two bits disagree -> overflowed; clamp toward the true sign.
    if (int_sum[INT_BITS] != int_sum[INT_BITS-1]) begin
      integral_d = int_sum[INT_BITS] ? {1'b1, {(INT_BITS-1){1'b0}}}
                                     : {1'b0, {(INT_BITS-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integral_q <= '0;
    end else if (win_done) begin
      integral_q <= integral_d;
    end
  end

  assign integ_term = PI_BITS'(integral_q >>> KI_SHIFT);
`else
  assign integ_term = '0;
`endif

  always_comb begin
    kp_term = '0;
    if (s2_pos_q) begin
      kp_term = PI_BITS'(KP);
    end else if (s2_neg_q) begin
      kp_term = PI_BITS'(-KP);
    end
    // Modulo 2^PI_BITS: the interpolator code is a phase and wraps.
    pi_code_d = pi_code_q + kp_term + integ_term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q     <= 1'b0;
      s2_pos_q     <= 1'b0;
      s2_neg_q     <= 1'b0;
      s2_quiet_q   <= 1'b0;
      s2_loud_q    <= 1'b0;
      pi_code_q    <= '0;
      code_valid_q <= 1'b0;
    end else begin
      s2_vld_q     <= win_done;
      code_valid_q <= s2_vld_q;
      if (win_done) begin
        s2_pos_q   <= !win_sum[SW-1] && (win_sum != '0);
        s2_neg_q   <= win_sum[SW-1];
        s2_quiet_q <= win_quiet;
        s2_loud_q  <= win_loud;
      end
      if (s2_vld_q) begin
        pi_code_q <= pi_code_d;
      end
    end
  end

  // Lock FSM evaluates each window on the same edge that publishes its code,
  // so locked moves together with code_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      quiet_cnt_q <= '0;
      locked_q    <= 1'b0;
    end else if (!bus.en) begin
      state_q     <= ST_IDLE;
      quiet_cnt_q <= '0;
      locked_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q  <= ST_ACQ;
          locked_q <= 1'b0;
        end
        ST_ACQ: begin
          if (s2_vld_q) begin
            if (s2_quiet_q) begin
              quiet_cnt_q <= quiet_cnt_q + 1'b1;
              if (quiet_cnt_q == QW'(LOCK_CNT - 1)) begin
                state_q  <= ST_TRACK;
                locked_q <= 1'b1;
              end
            end else begin
              quiet_cnt_q <= '0;
            end
          end
        end
        ST_TRACK: begin
          if (s2_vld_q) begin
            if (!s2_quiet_q) begin
              quiet_cnt_q <= '0;
            end
            if (s2_loud_q) begin
              state_q  <= ST_ACQ;
              locked_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pi_code    = pi_code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_bbpd_loop_ctrl.sv
// Directed bench for bbpd_loop_ctrl with a window-level model feeding a scoreboard queue.
// Expected code/lock/edge are pushed when a window closes and popped when code_valid is due.
// Works with and without BBPD_CTRL_INTEGRAL_EN.
module tb_bbpd_loop_ctrl;
  import bbpd_loop_ctrl_pkg::*;

  localparam int WIN      = 16;
  localparam int KP       = 2;
  localparam int KI_SHIFT = 4;
  localparam int LOCK     = 8;
  localparam int INT_MAX  = 2047;
  localparam int INT_MIN  = -2048;
`ifdef BBPD_CTRL_INTEGRAL_EN
  localparam int EXP_W1   = 3;
  localparam int EXP_W2   = 7;
  localparam int EXP_LONG = 235;
`else
  localparam int EXP_W1   = 2;
  localparam int EXP_W2   = 4;
  localparam int EXP_LONG = 88;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  bbpd_loop_ctrl_if #(.PI_BITS(8)) bus ();

  bbpd_loop_ctrl #(
    .WIN_LEN  (WIN),
    .PI_BITS  (8),
    .INT_BITS (12),
    .KP       (KP),
    .KI_SHIFT (KI_SHIFT),
    .LOCK_CNT (LOCK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    pi_code_t pi;
    logic     lk;
    int       at;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  pi_code_t    m_pi;
  int          m_integ;
  loop_state_t m_state;
  int          m_qcnt;
  int          m_wcnt;
  int          m_wsum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_pi    = '0;
    m_integ = 0;
    m_state = ST_IDLE;
    m_qcnt  = 0;
    m_wcnt  = 0;
    m_wsum  = 0;
    sb.delete();
  endtask

  task automatic model_close();
    int sgn, upd, mag;
    exp_t e;
    sgn = (m_wsum > 0) ? 1 : ((m_wsum < 0) ? -1 : 0);
`ifdef BBPD_CTRL_INTEGRAL_EN
    m_integ = m_integ + m_wsum;
    if (m_integ > INT_MAX) m_integ = INT_MAX;
    if (m_integ < INT_MIN) m_integ = INT_MIN;
    upd = KP * sgn + (m_integ >>> KI_SHIFT);
`else
    upd = KP * sgn;
`endif
    m_pi = pi_code_t'(int'(m_pi) + upd);
    mag = (m_wsum < 0) ? -m_wsum : m_wsum;
    if (m_state == ST_ACQ) begin
      if (mag <= 1) begin
        m_qcnt++;
        if (m_qcnt == LOCK) m_state = ST_TRACK;
      end else begin
        m_qcnt = 0;
      end
    end else if (m_state == ST_TRACK) begin
      if (mag > 1) m_qcnt = 0;
      if (mag > WIN / 2) m_state = ST_ACQ;
    end
    e.pi = m_pi;
    e.lk = (m_state == ST_TRACK);
    e.at = edge_n + 2;
    sb.push_back(e);
    m_wcnt = 0;
    m_wsum = 0;
  endtask

  task automatic model_edge(input logic e, input logic u, input logic d);
    if (!e) begin
      m_state = ST_IDLE;
      m_qcnt  = 0;
      m_wcnt  = 0;
      m_wsum  = 0;
      // A pending update still lands, but the loop has already dropped to idle.
      foreach (sb[i]) sb[i].lk = 1'b0;
    end else begin
      if (m_state == ST_IDLE) m_state = ST_ACQ;
      if (u && !d) m_wsum++;
      else if (d && !u) m_wsum--;
      m_wcnt++;
      if (m_wcnt == WIN) model_close();
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() > 0 && (bus.code_valid === 1'b1 || sb[0].at <= edge_n)) begin
      e = sb.pop_front();
      chk("cv_edge", (bus.code_valid === 1'b1) ? edge_n : 0, e.at);
      chk("pi_code", bus.pi_code, e.pi);
      chk("locked", bus.locked, e.lk);
    end else if (bus.code_valid !== 1'b0) begin
      chk("stray_code_valid", bus.code_valid, 0);
    end
  endtask

  task automatic step(input logic e, input logic u, input logic d);
    bus.en = e;
    bus.up = u;
    bus.dn = d;
    @(posedge clk);
    edge_n++;
    model_edge(e, u, d);
    @(negedge clk);
    check_out();
  endtask

  task automatic run(input int n, input logic e, input logic u, input logic d);
    for (int i = 0; i < n; i++) step(e, u, d);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    rst    = 1'b1;
    bus.en = 1'b0;
    bus.up = 1'b0;
    bus.dn = 1'b0;
    #1;
    chk("rst_pi_code", bus.pi_code, 0);
    chk("rst_code_valid", bus.code_valid, 0);
    chk("rst_locked", bus.locked, 0);
`ifdef BBPD_CTRL_INTEGRAL_EN
    chk("rst_integral", dut.integral_q, 0);
`endif
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.up = 1'b0;
    bus.dn = 1'b0;
    model_clear();

    // Two all-up windows.
    do_reset();
    run(16, 1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1, 1'b0);
    chk("up_win1_pi", bus.pi_code, EXP_W1);
    run(14, 1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1, 1'b1);
    chk("up_win2_pi", bus.pi_code, EXP_W2);

    // Both votes asserted: zero update, code_valid still pulses.
    do_reset();
    run(16, 1'b1, 1'b1, 1'b1);
    run(2, 1'b1, 1'b1, 1'b1);
    chk("zero_win_pi", bus.pi_code, 0);
    chk("zero_win_locked", bus.locked, 0);

    // Eight quiet windows lock; a strongly negative window unlocks.
    do_reset();
    for (int w = 0; w < LOCK; w++) begin
      for (int i = 0; i < WIN; i++) step(1'b1, (i % 2) == 0, (i % 2) == 1);
    end
    run(2, 1'b1, 1'b1, 1'b1);
    chk("lock_after_8", bus.locked, 1);
    run(14, 1'b1, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1, 1'b1);
    chk("unlock_after_dn", bus.locked, 0);

    // Enable drops mid-window: partial window discarded.
    do_reset();
    run(7, 1'b1, 1'b1, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0);
    chk("en_drop_pi_held", bus.pi_code, 0);
    run(15, 1'b1, 1'b1, 1'b0);
    chk("en_drop_no_early_cv", bus.code_valid, 0);
    run(1, 1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1, 1'b1);
    chk("en_drop_full_win_pi", bus.pi_code, EXP_W1);

    // Enable drops right after the closing vote: update still lands.
    do_reset();
    run(16, 1'b1, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    chk("close_edge_pi", bus.pi_code, EXP_W1);
    chk("close_edge_locked", bus.locked, 0);

    // Reset mid-window, then a fresh full window.
    run(8, 1'b1, 1'b1, 1'b0);
    do_reset();
    run(16, 1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1, 1'b1);
    chk("post_rst_win_pi", bus.pi_code, EXP_W1);

    // Long sustained up: integral saturation and code wrap.
    do_reset();
    run(300 * WIN, 1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1, 1'b1);
    chk("long_run_pi", bus.pi_code, EXP_LONG);
`ifdef BBPD_CTRL_INTEGRAL_EN
    chk("integral_sat", dut.integral_q, 2047);
`endif

    run(3, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
